// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and load/store via a req/gnt/resp FSM.
// Define ARB_RR_EN for round-robin arbitration; otherwise data has fixed priority over fetch.
module mem_port_arbiter #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic [31:0]         i_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                m_req,
    output logic                m_we,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_be,
    input  logic                m_gnt,
    input  logic                m_rvalid,
    input  logic [DATA_W-1:0]   m_rdata,
    output logic                busy,
    output logic                timeout_err
);
    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;
    state_t                r_state, w_next;
    logic                  r_owner_d, r_word_hi, r_to, r_gnt_seen;
    logic [15:0]           r_cnt;
    logic [DATA_W-1:0]     r_data;
    logic                  r_m_req, r_m_we;
    logic [ADDR_W-1:0]     r_m_addr;
    logic [DATA_W-1:0]     r_m_wdata;
    logic [DATA_W/8-1:0]   r_m_be;
    logic                  w_start, w_pick_d, w_expired, w_abort;

    assign w_start   = (r_state == IDLE) && (i_req || d_req);
    assign w_expired = r_cnt >= 16'(TIMEOUT - 1);

`ifdef ARB_RR_EN
    logic r_last_d;
    assign w_pick_d = d_req && (!i_req || !r_last_d);
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_last_d <= 1'b1;
        else if (w_start)
            r_last_d <= w_pick_d;
    end
`else
    assign w_pick_d = d_req;
`endif

    always_comb begin
        w_next  = r_state;
        w_abort = 1'b0;
        case (r_state)
            IDLE: if (i_req || d_req) w_next = REQ;
            REQ: begin
                if (m_gnt)
                    w_next = RESP;
                else if (w_expired) begin
                    w_next  = DONE;
                    w_abort = 1'b1;
                end
            end
            RESP: begin
                if (m_rvalid)
                    w_next = DONE;
                else if (w_expired) begin
                    w_next  = DONE;
                    w_abort = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_owner_d  <= 1'b0;
            r_word_hi  <= 1'b0;
            r_to       <= 1'b0;
            r_gnt_seen <= 1'b0;
            r_cnt      <= '0;
            r_data     <= '0;
            r_m_req    <= 1'b0;
            r_m_we     <= 1'b0;
            r_m_addr   <= '0;
            r_m_wdata  <= '0;
            r_m_be     <= '0;
        end else begin
            r_state <= w_next;
            r_m_req <= (w_next == REQ);
            if (w_start) begin
                r_owner_d  <= w_pick_d;
                r_word_hi  <= i_addr[2];
                r_to       <= 1'b0;
                r_gnt_seen <= 1'b0;
                r_cnt      <= '0;
                r_m_we     <= w_pick_d ? d_we : 1'b0;
                r_m_addr   <= w_pick_d ? d_addr : i_addr;
                r_m_wdata  <= w_pick_d ? d_wdata : '0;
                r_m_be     <= w_pick_d ? d_be : '1;
            end else if (r_state == REQ || r_state == RESP)
                r_cnt <= r_cnt + 16'd1;
            if (r_state == REQ && m_gnt)
                r_gnt_seen <= 1'b1;
            if (r_state == RESP && m_rvalid)
                r_data <= m_rdata;
            if (w_abort) begin
                r_to   <= 1'b1;
                r_data <= '0;
            end
        end
    end

    // An abort before grant still pulses x_gnt so the requester drops its request.
    logic w_gnt, w_done;
    assign w_done      = (r_state == DONE);
    assign w_gnt       = ((r_state == REQ) && m_gnt) || (w_done && r_to && !r_gnt_seen);
    assign i_gnt       = w_gnt && !r_owner_d;
    assign d_gnt       = w_gnt && r_owner_d;
    assign i_rvalid    = w_done && !r_owner_d;
    assign d_rvalid    = w_done && r_owner_d;
    assign d_rdata     = r_data;
    assign i_rdata     = r_word_hi ? r_data[32 +: 32] : r_data[0 +: 32];
    assign timeout_err = w_done && r_to;
    assign busy        = (r_state != IDLE);
    assign m_req       = r_m_req;
    assign m_we        = r_m_we;
    assign m_addr      = r_m_addr;
    assign m_wdata     = r_m_wdata;
    assign m_be        = r_m_be;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vector table plus hand sequences for reset, tie and timeout.
module tb_mem_port_arbiter;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        i_req = 0, i_gnt, i_rvalid;
    logic [63:0] i_addr = '0;
    logic [31:0] i_rdata;
    logic        d_req = 0, d_we = 0, d_gnt, d_rvalid;
    logic [63:0] d_addr = '0, d_wdata = '0, d_rdata;
    logic [7:0]  d_be = '0, m_be;
    logic        m_req, m_we, m_gnt = 0, m_rvalid = 0, busy, timeout_err;
    logic [63:0] m_addr, m_wdata, m_rdata = '0;
    int n_tests = 0, n_fail = 0;

    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
        .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_d;
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  be;
        int          gd;
        logic [63:0] rdata;
        logic        exp_we;
        logic [7:0]  exp_be;
        logic [63:0] exp_wdata;
        logic [63:0] exp_rd;
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string t;
        t = $sformatf("v%0d", idx);
        if (v.is_d) begin
            d_req = 1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_be = v.be;
        end else begin
            i_req = 1; i_addr = v.addr;
        end
        step();
        chk({t, ".m_addr"}, m_addr, v.addr);
        for (int k = 0; k <= v.gd; k++) begin
            chk({t, ".m_req"}, 64'(m_req), 64'd1);
            chk({t, ".m_we"}, 64'(m_we), 64'(v.exp_we));
            chk({t, ".m_be"}, 64'(m_be), 64'(v.exp_be));
            if (v.is_d) chk({t, ".m_wdata"}, m_wdata, v.exp_wdata);
            if (k == v.gd) m_gnt = 1;
            #1;
            chk({t, ".own_gnt"}, 64'(v.is_d ? d_gnt : i_gnt), 64'(k == v.gd));
            chk({t, ".oth_gnt"}, 64'(v.is_d ? i_gnt : d_gnt), 64'd0);
            step();
            m_gnt = 0;
        end
        i_req = 0; d_req = 0;
        chk({t, ".resp_m_req"}, 64'(m_req), 64'd0);
        m_rvalid = 1; m_rdata = v.rdata;
        step();
        m_rvalid = 0;
        chk({t, ".own_rvalid"}, 64'(v.is_d ? d_rvalid : i_rvalid), 64'd1);
        chk({t, ".oth_rvalid"}, 64'(v.is_d ? i_rvalid : d_rvalid), 64'd0);
        chk({t, ".rdata"}, v.is_d ? d_rdata : 64'(i_rdata), v.exp_rd);
        chk({t, ".to_err"}, 64'(timeout_err), 64'd0);
        chk({t, ".busy_done"}, 64'(busy), 64'd1);
        step();
        chk({t, ".busy_idle"}, 64'(busy), 64'd0);
    endtask

    task automatic serve_tie(input logic exp_d, input logic [63:0] exp_addr,
                             input logic [63:0] rdata, input logic [63:0] exp_rd, input string t);
        step();
        chk({t, ".m_addr"}, m_addr, exp_addr);
        m_gnt = 1;
        #1;
        chk({t, ".d_gnt"}, 64'(d_gnt), 64'(exp_d));
        chk({t, ".i_gnt"}, 64'(i_gnt), 64'(!exp_d));
        step();
        m_gnt = 0;
        if (exp_d) d_req = 0; else i_req = 0;
        m_rvalid = 1; m_rdata = rdata;
        step();
        m_rvalid = 0;
        chk({t, ".rvalid"}, 64'(exp_d ? d_rvalid : i_rvalid), 64'd1);
        chk({t, ".rdata"}, exp_d ? d_rdata : 64'(i_rdata), exp_rd);
        step();
    endtask

    task automatic chk_zero(input string t);
        chk({t, ".busy"}, 64'(busy), 64'd0);
        chk({t, ".m_req"}, 64'(m_req), 64'd0);
        chk({t, ".m_we"}, 64'(m_we), 64'd0);
        chk({t, ".m_addr"}, m_addr, 64'd0);
        chk({t, ".m_wdata"}, m_wdata, 64'd0);
        chk({t, ".m_be"}, 64'(m_be), 64'd0);
        chk({t, ".gnts"}, 64'({i_gnt, d_gnt}), 64'd0);
        chk({t, ".rvalids"}, 64'({i_rvalid, d_rvalid}), 64'd0);
        chk({t, ".d_rdata"}, d_rdata, 64'd0);
        chk({t, ".i_rdata"}, 64'(i_rdata), 64'd0);
        chk({t, ".to_err"}, 64'(timeout_err), 64'd0);
    endtask

    initial begin
        vecs[0] = '{1, 0, 64'h100, 64'h0, 8'hFF, 0, 64'h1122334455667788, 0, 8'hFF, 64'h0, 64'h1122334455667788};
        vecs[1] = '{0, 0, 64'h4, 64'h0, 8'h0, 0, 64'hDEADBEEF00000013, 0, 8'hFF, 64'h0, 64'hDEADBEEF};
        vecs[2] = '{0, 0, 64'h0, 64'h0, 8'h0, 0, 64'hDEADBEEF00000013, 0, 8'hFF, 64'h0, 64'h00000013};
        vecs[3] = '{1, 1, 64'h200, 64'hCAFEF00D12345678, 8'h0F, 3, 64'h0, 1, 8'h0F, 64'hCAFEF00D12345678, 64'h0};
        vecs[4] = '{1, 0, 64'h108, 64'h0, 8'hFF, 2, 64'hA5A5A5A55A5A5A5A, 0, 8'hFF, 64'h0, 64'hA5A5A5A55A5A5A5A};
        vecs[5] = '{0, 0, 64'h1004, 64'h0, 8'h0, 1, 64'h0123456789ABCDEF, 0, 8'hFF, 64'h0, 64'h01234567};

        step();
        step();
        chk_zero("reset");
        rst_n = 1;
        step();

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Reset while in RESP, then a late response must not surface.
        d_req = 1; d_we = 0; d_addr = 64'h500; d_be = 8'hFF;
        step();
        m_gnt = 1;
        step();
        m_gnt = 0; d_req = 0;
        rst_n = 0;
        step();
        rst_n = 1;
        chk_zero("rst_mid");
        m_rvalid = 1; m_rdata = 64'h7777777777777777;
        step();
        m_rvalid = 0;
        chk("rst_late.rvalids", 64'({i_rvalid, d_rvalid}), 64'd0);
        chk("rst_late.busy", 64'(busy), 64'd0);
        step();
        chk("rst_late2.rvalids", 64'({i_rvalid, d_rvalid}), 64'd0);

        // Simultaneous requests held across two transactions.
        d_req = 1; d_we = 0; d_addr = 64'h300; d_be = 8'hFF;
        i_req = 1; i_addr = 64'h44;
`ifdef ARB_RR_EN
        serve_tie(0, 64'h44, 64'h3333333344444444, 64'h33333333, "tie1");
        serve_tie(1, 64'h300, 64'h0000000011112222, 64'h0000000011112222, "tie2");
`else
        serve_tie(1, 64'h300, 64'h0000000011112222, 64'h0000000011112222, "tie1");
        serve_tie(0, 64'h44, 64'h3333333344444444, 64'h33333333, "tie2");
`endif
        chk("tie.busy", 64'(busy), 64'd0);

        // Memory never grants: abort after 8 cycles in REQ.
        d_req = 1; d_we = 0; d_addr = 64'h600; d_be = 8'hFF;
        step();
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("to.wait%0d", k), 64'({m_req, d_gnt, d_rvalid, timeout_err}), 64'b1000);
            step();
        end
        chk("to.d_gnt", 64'(d_gnt), 64'd1);
        chk("to.d_rvalid", 64'(d_rvalid), 64'd1);
        chk("to.err", 64'(timeout_err), 64'd1);
        chk("to.d_rdata", d_rdata, 64'd0);
        chk("to.i_side", 64'({i_gnt, i_rvalid}), 64'd0);
        d_req = 0;
        m_rvalid = 1; m_rdata = 64'h9999999999999999;
        step();
        m_rvalid = 0;
        chk("to.after", 64'({busy, m_req, d_rvalid, timeout_err}), 64'd0);
        step();
        chk("to.late", 64'({d_rvalid, d_rdata != 64'd0}), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

- Shares one memory port between the instruction-fetch requester and the load/store requester of the RISC-V core.
- Sequences each access through a request/grant/response state machine, one transaction outstanding at a time.
- Steers read data back to the owning requester and flags memory that never responds.
- Sits between the fetch/memory stages and the unified instruction/data memory.

## Interface
- ADDR_W, 64, address width of all ports
- DATA_W, 64, memory/data width; byte-enable width is DATA_W/8
- TIMEOUT, 255, max cycles from entering REQ to `m_rvalid` before abort (1..65535)

- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- i_req  in  1  fetch request; held with i_addr stable until i_gnt
- i_addr  in  ADDR_W  fetch byte address
- i_gnt  out  1  fetch accepted (one-cycle pulse)
- i_rvalid  out  1  fetch data valid (one-cycle pulse)
- i_rdata  out  32  instruction word
- d_req  in  1  data request; held with d_we/d_addr/d_wdata/d_be stable until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data byte address
- d_wdata  in  DATA_W  store data
- d_be  in  DATA_W/8  byte enables
- d_gnt  out  1  data accepted (one-cycle pulse)
- d_rvalid  out  1  load data / store ack (one-cycle pulse)
- d_rdata  out  DATA_W  load data
- m_req, m_we, m_addr, m_wdata, m_be  out  1/1/ADDR_W/DATA_W/DATA_W/8  memory request, registered
- m_gnt  in  1  memory accepts request this cycle
- m_rvalid  in  1  memory response (read data or write ack)
- m_rdata  in  DATA_W  memory read data
- busy  out  1  state != IDLE
- timeout_err  out  1  one-cycle pulse on timeout abort

## Operation
- States: IDLE, REQ, RESP, DONE.
- IDLE: if any request, arbitrate, capture winner's fields into m_* registers, record owner and i_addr[2]; go to REQ.
- REQ: m_req=1. On m_gnt: pulse owner's x_gnt (combinational, same cycle), go to RESP. For i-owner, m_we=0 and m_be all-ones.
- RESP: m_req=0. On m_rvalid: capture m_rdata, go to DONE.
- DONE: pulse owner's x_rvalid with registered data, go to IDLE.
  - d_rdata = captured data.
  - i_rdata = captured[63:32] if captured i_addr[2] else [31:0].
- Fixed priority: data wins over fetch when both requested in the same IDLE cycle.
- Timeout counter: cleared on IDLE→REQ, increments each cycle in REQ/RESP.
  - On reaching TIMEOUT without completion: go to DONE with data forced to 0, pulse timeout_err with x_rvalid.
  - If m_gnt was never seen, also pulse x_gnt in that DONE cycle so the requester releases.
- m_rvalid outside RESP is ignored (late response after abort dropped).
- m_gnt and m_rvalid in the same cycle while in REQ: grant only; m_rvalid ignored (memory must respond ≥1 cycle after gnt).
- A request deasserted before grant violates protocol; behaviour undefined, not checked.

## Timing
- Reset (rst_n=0 at an edge): state IDLE, counter 0, every output 0 next cycle; in-flight transaction dropped, no x_rvalid.
- Minimum access: req high in cycle N (IDLE) → m_req cycle N+1 → with m_gnt at N+1, x_gnt at N+1 → m_rvalid at N+2 → x_rvalid/x_rdata at N+3.
- Back-to-back: next arbitration in the cycle after DONE; minimum 4 cycles per transaction.
- busy is high from N+1 through the DONE cycle inclusive.

## Configuration
- ARB_RR_EN defined: round-robin arbitration.
  - Last-served flag, reset to "data".
  - On a tie, the requester not served last wins; flag updates on every IDLE→REQ.
- ARB_RR_EN undefined: fixed data-over-fetch priority, no flag.

## Test plan
- Reset mid-RESP (rst_n=0 one cycle) → all outputs 0, state IDLE; a later m_rvalid produces no x_rvalid.
- Single load: d_req, d_addr=0x100; m_gnt immediate; m_rvalid next cycle with m_rdata=0x1122334455667788 → d_gnt at cycle 1, d_rvalid with d_rdata=0x1122334455667788 at cycle 3.
- Fetch with i_addr=0x4, m_rdata=0xDEADBEEF_00000013 → i_rdata=0xDEADBEEF; with i_addr=0x0 → 0x00000013.
- i_req and d_req both held for two transactions → default: data served first, then fetch; with ARB_RR_EN: fetch first, then data.
- TIMEOUT=8, m_gnt never asserted → at cycle 8 in REQ: x_gnt, x_rvalid and timeout_err pulse together, data 0, state IDLE.
- Store with d_be=0x0F, m_gnt held low 3 cycles → m_req/m_we/m_be/m_wdata stable throughout; d_gnt only on the m_gnt cycle.
